// File: rtl/m6502_agu.sv
// m6502_agu: address-generation and memory-access sequencer for the 6502 core.
// Takes one request from decode, walks operand/pointer fetches over a
// ready-handshaked bus, performs the final load/store and returns data / EA.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   start, mode, kind         request strobe and addressing mode / access kind
//   op_addr                   first operand byte address (or vector address)
//   reg_x, reg_y, wr_value    index registers and store data, latched at start
//   addr, rd_req, wr_en,
//   wr_data, rd_data, ready   memory bus (one transaction held until ready=1)
//   busy, done                sequencer status, done is a one-cycle pulse
//   data_out, ea, page_cross  loaded byte, effective address, index carry
//
// Build option: define M6502_JMP_IND_BUG_EN to reproduce the NMOS JMP (ind)
// page-wrap on the pointer high-byte fetch; undefined gives 65C02 behaviour.
module m6502_agu #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ZP_WRAP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        mode,
    input  logic [1:0]        kind,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] reg_x,
    input  logic [DATA_W-1:0] reg_y,
    input  logic [DATA_W-1:0] wr_value,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_req,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] ea,
    output logic              page_cross
);

    localparam logic [3:0] M_VECTOR  = 4'd1;
    localparam logic [3:0] M_IMM     = 4'd3;
    localparam logic [3:0] M_Z       = 4'd4;
    localparam logic [3:0] M_Z_X     = 4'd5;
    localparam logic [3:0] M_Z_Y     = 4'd6;
    localparam logic [3:0] M_ABS     = 4'd7;
    localparam logic [3:0] M_ABS_X   = 4'd8;
    localparam logic [3:0] M_ABS_Y   = 4'd9;
    localparam logic [3:0] M_IND_X   = 4'd11;
    localparam logic [3:0] M_IND_Y   = 4'd12;
    localparam logic [3:0] M_IND_ABS = 4'd13;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_ADDR  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI, S_ACCESS, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic [1:0]        kind_q, kind_d;
    logic [ADDR_W-1:0] op_q, op_d;
    logic [7:0]        x_q, x_d, y_q, y_d, lo_q, lo_d;
    logic [DATA_W-1:0] wv_q, wv_d, dout_q, dout_d;
    logic [15:0]       ptr_q, ptr_d, ea_q, ea_d;
    logic              pc_q, pc_d, fix_q, fix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_req_q, rd_req_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              xfer;
    logic [7:0]        rd_byte, zidx, aidx;
    logic [15:0]       word, zsum;
    logic [16:0]       asum;

    // Zero-page base + index, optionally wrapped inside page 0.
    function automatic logic [15:0] zp_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (ZP_WRAP != 0) zp_add = {8'h00, s[7:0]};
        else              zp_add = {7'h00, s};
    endfunction

    // 16-bit base + index; bit 16 is the carry out of the low byte.
    function automatic logic [16:0] idx_add(input logic [15:0] w, input logic [7:0] i);
        logic [8:0] ls;
        ls = {1'b0, w[7:0]} + {1'b0, i};
        idx_add = {ls[8], w + {8'h00, i}};
    endfunction

    // Address of the pointer high byte.
    function automatic logic [15:0] ptr_inc(input logic [15:0] p, input logic [3:0] m);
        logic [15:0] same_page;
        same_page = {p[15:8], p[7:0] + 8'd1};
        if (m == M_IND_ABS) begin
`ifdef M6502_JMP_IND_BUG_EN
            ptr_inc = same_page;
`else
            ptr_inc = p + 16'd1;
`endif
        end else if (ZP_WRAP != 0) begin
            ptr_inc = same_page;
        end else begin
            ptr_inc = p + 16'd1;
        end
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            kind_q    <= '0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            lo_q      <= '0;
            wv_q      <= '0;
            dout_q    <= '0;
            ptr_q     <= '0;
            ea_q      <= '0;
            pc_q      <= 1'b0;
            fix_q     <= 1'b0;
            addr_q    <= '0;
            rd_req_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            kind_q    <= kind_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lo_q      <= lo_d;
            wv_q      <= wv_d;
            dout_q    <= dout_d;
            ptr_q     <= ptr_d;
            ea_q      <= ea_d;
            pc_q      <= pc_d;
            fix_q     <= fix_d;
            addr_q    <= addr_d;
            rd_req_q  <= rd_req_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        kind_d  = kind_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        lo_d    = lo_q;
        wv_d    = wv_q;
        dout_d  = dout_q;
        ptr_d   = ptr_q;
        ea_d    = ea_q;
        pc_d    = pc_q;
        fix_d   = fix_q;
        xfer    = (rd_req_q | wr_en_q) & ready;
        rd_byte = rd_data[7:0];
        word    = {rd_byte, lo_q};
        zidx    = 8'h00;
        if (mode_q == M_Z_X || mode_q == M_IND_X) zidx = x_q;
        else if (mode_q == M_Z_Y)                 zidx = y_q;
        aidx    = 8'h00;
        if (mode_q == M_ABS_X)                             aidx = x_q;
        else if (mode_q == M_ABS_Y || mode_q == M_IND_Y)   aidx = y_q;
        zsum    = zp_add(rd_byte, zidx);
        asum    = idx_add(word, aidx);

        case (state_q)
            S_IDLE: if (start) begin
                mode_d = mode;
                kind_d = kind;
                op_d   = op_addr;
                x_d    = reg_x[7:0];
                y_d    = reg_y[7:0];
                wv_d   = wr_value;
                pc_d   = 1'b0;
                fix_d  = 1'b0;
                if (kind == K_NONE) begin
                    state_d = S_DONE;
                end else begin
                    case (mode)
                        M_IMM: begin
                            state_d = S_ACCESS;
                            ea_d    = op_addr[15:0];
                            if (kind == K_STORE) kind_d = K_LOAD;
                        end
                        M_VECTOR, M_Z, M_Z_X, M_Z_Y, M_ABS, M_ABS_X, M_ABS_Y,
                        M_IND_X, M_IND_Y, M_IND_ABS: state_d = S_OP_LO;
                        default: state_d = S_DONE;   // IMPL and unused codes
                    endcase
                end
            end
            S_OP_LO: if (xfer) begin
                lo_d = rd_byte;
                case (mode_q)
                    M_Z, M_Z_X, M_Z_Y: begin
                        ea_d    = zsum;
                        state_d = S_ACCESS;
                    end
                    M_IND_X: begin
                        ptr_d   = zsum;
                        state_d = S_PTR_LO;
                    end
                    M_IND_Y: begin
                        ptr_d   = {8'h00, rd_byte};
                        state_d = S_PTR_LO;
                    end
                    default: state_d = S_OP_HI;
                endcase
            end
            S_OP_HI: if (xfer) begin
                case (mode_q)
                    M_VECTOR: begin
                        ea_d    = word;
                        state_d = S_DONE;
                    end
                    M_IND_ABS: begin
                        ptr_d   = word;
                        state_d = S_PTR_LO;
                    end
                    default: begin
                        ea_d    = asum[15:0];
                        pc_d    = asum[16];
                        state_d = S_ACCESS;
                    end
                endcase
            end
            S_PTR_LO: if (xfer) begin
                lo_d    = rd_byte;
                state_d = S_PTR_HI;
            end
            S_PTR_HI: if (xfer) begin
                case (mode_q)
                    M_IND_ABS: begin
                        ea_d    = word;
                        state_d = S_DONE;
                    end
                    M_IND_Y: begin
                        // Y is applied in a bubble cycle before the access.
                        ea_d    = asum[15:0];
                        pc_d    = asum[16];
                        fix_d   = 1'b1;
                        state_d = S_ACCESS;
                    end
                    default: begin
                        ea_d    = word;
                        state_d = S_ACCESS;
                    end
                endcase
            end
            S_ACCESS: begin
                if (fix_q) begin
                    fix_d = 1'b0;
                end else if (kind_q == K_ADDR) begin
                    state_d = S_DONE;
                end else if (xfer) begin
                    if (kind_q == K_LOAD) dout_d = rd_data;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered bus/status outputs for the state being entered.
    always_comb begin
        addr_d    = addr_q;
        rd_req_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        case (state_d)
            S_OP_LO: begin
                addr_d   = op_d;
                rd_req_d = 1'b1;
            end
            S_OP_HI: begin
                addr_d   = op_d + ADDR_W'(1);
                rd_req_d = 1'b1;
            end
            S_PTR_LO: begin
                addr_d   = ADDR_W'(ptr_d);
                rd_req_d = 1'b1;
            end
            S_PTR_HI: begin
                addr_d   = ADDR_W'(ptr_inc(ptr_d, mode_d));
                rd_req_d = 1'b1;
            end
            S_ACCESS: if (!fix_d) begin
                if (kind_d == K_LOAD) begin
                    addr_d   = ADDR_W'(ea_d);
                    rd_req_d = 1'b1;
                end else if (kind_d == K_STORE) begin
                    addr_d    = ADDR_W'(ea_d);
                    wr_en_d   = 1'b1;
                    wr_data_d = wv_d;
                end
            end
            default: ;
        endcase
    end

    assign addr       = addr_q;
    assign rd_req     = rd_req_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = dout_q;
    assign ea         = ADDR_W'(ea_q);
    assign page_cross = pc_q;

endmodule

// File: doc/m6502_agu.md
Name: m6502_agu

Overview:
Parametrised address-generation and memory-access sequencer for the 6502 core. It replaces the ad-hoc address-mode logic inside the CPU with a standalone unit covering every 6502 addressing mode, plus vector loads, with correct zero-page wrap and page-cross reporting. The decode stage issues one request. The unit walks operand/pointer fetches over a ready-handshaked bus, performs the final load or store, and returns the data or effective address.

Parameters:
ADDR_W, 16, bus address width (>=16; upper bits zero-extended)
DATA_W, 8, bus data width
ZP_WRAP, 1, 1 = zero-page index/pointer arithmetic wraps within page 0; 0 = carries into page 1

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
start  in  1  request strobe, sampled only in IDLE
mode  in  4  0 IMPL, 1 VECTOR, 3 IMM, 4 Z, 5 Z_X, 6 Z_Y, 7 ABS, 8 ABS_X, 9 ABS_Y, 11 IND_X, 12 IND_Y, 13 IND_ABS
kind  in  2  0 NONE, 1 LOAD, 2 STORE, 3 ADDR_ONLY
op_addr  in  ADDR_W  address of first operand byte (pc+1), or vector address for VECTOR
reg_x  in  DATA_W  X index, latched at start
reg_y  in  DATA_W  Y index, latched at start
wr_value  in  DATA_W  store data, latched at start
addr  out  ADDR_W  bus address
rd_req  out  1  bus read request
wr_en  out  1  bus write request
wr_data  out  DATA_W  bus write data
rd_data  in  DATA_W  bus read data, valid when ready=1 during rd_req
ready  in  1  bus completes current transaction this cycle
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse
data_out  out  DATA_W  loaded byte, valid from done until next start
ea  out  ADDR_W  effective address, or 16-bit word for VECTOR/IND_ABS
page_cross  out  1  index addition carried into the high byte (ABS_X, ABS_Y, IND_Y)

Behaviour:
- Reset: state IDLE; addr, wr_data, data_out and ea = 0; rd_req, wr_en, busy, done, page_cross = 0. Reset mid-operation aborts immediately. No partial write is issued after reset.
- Bus rule: a transaction presents addr/rd_req or addr/wr_en/wr_data, held stable until a cycle with ready=1. The transaction completes in that cycle and rd_data is captured then. Transactions are never back-to-back combinational: the next one starts the following cycle. rd_req and wr_en are never both high.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, ACCESS, DONE.
- IDLE + start:
  - mode IMPL or kind NONE -> DONE directly.
  - IMM -> ACCESS at op_addr. STORE is treated as LOAD.
  - all other modes -> OP_LO.
- OP_LO: read op_addr; low byte -> lo.
  - Z / Z_X / Z_Y: ea = lo + index, wrapped to 8 bits if ZP_WRAP -> ACCESS.
  - ABS*: -> OP_HI.
  - IND_X: ptr = lo + X (zero-page wrap) -> PTR_LO.
  - IND_Y: ptr = lo -> PTR_LO.
  - VECTOR: -> OP_HI.
- OP_HI: read op_addr+1; hi.
  - ABS / ABS_X / ABS_Y: ea = {hi,lo} + index, modulo 2^16; page_cross = carry out of low byte -> ACCESS.
  - VECTOR: ea = {hi,lo} -> DONE.
  - IND_ABS: ptr = {hi,lo} -> PTR_LO.
- PTR_LO: read ptr -> PTR_HI.
- PTR_HI: read ptr+1. For IND_X/IND_Y the ptr+1 wraps in page 0 when ZP_WRAP=1.
  - IND_ABS: ea = word -> DONE.
  - IND_Y: ea = word + Y; page_cross as for ABS_Y -> ACCESS.
  - IND_X: ea = word -> ACCESS.
- ACCESS:
  - ADDR_ONLY: no bus cycle -> DONE.
  - LOAD: read ea, data_out <= rd_data -> DONE.
  - STORE: write wr_value at ea -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE. start in the DONE cycle is ignored.
- start while busy is ignored. Inputs other than rd_data/ready are don't-care after the start cycle.
- ready low stalls indefinitely with all bus outputs held.
- Latency with ready=1 always:
  - IMM LOAD: 3 cycles start->done.
  - Z LOAD: 4 cycles.
  - ABS LOAD: 5 cycles.
  - IND_Y LOAD: 7 cycles.

Optional Feature:
M6502_JMP_IND_BUG_EN:
- Defined: for IND_ABS, the pointer high-byte read uses {ptr[15:8], ptr[7:0]+1}, so the page does not increment (NMOS behaviour).
- Undefined: the read uses full 16-bit ptr+1 (65C02 behaviour).

Test Plan:
- Reset vector: mode VECTOR, op_addr=FFFC, mem FFFC=34, FFFD=12, ready=1 -> reads FFFC then FFFD; ea=1234, done at cycle 4.
- Z_X wrap: op byte=F0, X=20, LOAD, mem 0010=5A, ZP_WRAP=1 -> final read at 0010; data_out=5A; page_cross=0.
- ABS_Y page cross, STORE: operand 20FF, Y=01, wr_value=AA -> write AA at 2100; page_cross=1; wr_en high exactly one completed cycle.
- IND_Y with stalls: op=80, mem 0080=00, 0081=30, Y=05, mem 3005=77, ready toggling 1-0-1 -> data_out=77; addr/rd_req stable during ready=0; done after final ready.
- JMP indirect: IND_ABS ADDR_ONLY, pointer 10FF, mem 10FF=CD, 1100=AB, 1000=EF -> ea=ABCD without the macro, EFCD with M6502_JMP_IND_BUG_EN.
- Reset mid-operation: reset_n low during PTR_HI of IND_X STORE -> next cycle rd_req=wr_en=busy=0, no write issued; a new start after reset completes normally.
